// File: rtl/gpio_ctrl.sv
// Memory-mapped GPIO bank: output data/direction registers, 2-flop input synchronizer,
// per-pin edge interrupts with write-1-to-clear status and a registered level irq.
module gpio_ctrl #(
    parameter int unsigned NPINS  = 24,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o,
    output logic              ack_o,
    input  logic [NPINS-1:0]  gpio_i,
    output logic [NPINS-1:0]  gpio_o,
    output logic [NPINS-1:0]  gpio_oe_o,
    output logic              irq_o
);

    localparam logic [ADDR_W-1:0] AddrOut = ADDR_W'(32'h00);
    localparam logic [ADDR_W-1:0] AddrDir = ADDR_W'(32'h04);
    localparam logic [ADDR_W-1:0] AddrIn  = ADDR_W'(32'h08);
    localparam logic [ADDR_W-1:0] AddrIe  = ADDR_W'(32'h0C);
    localparam logic [ADDR_W-1:0] AddrPol = ADDR_W'(32'h10);
    localparam logic [ADDR_W-1:0] AddrIs  = ADDR_W'(32'h14);

    logic [NPINS-1:0] out_q, out_d;
    logic [NPINS-1:0] dir_q, dir_d;
    logic [NPINS-1:0] ie_q, ie_d;
    logic [NPINS-1:0] pol_q, pol_d;
    logic [NPINS-1:0] is_q, is_d;
    logic [NPINS-1:0] sync1_q, sync1_d;
    logic [NPINS-1:0] sync2_q, sync2_d;
    logic [NPINS-1:0] prev_q, prev_d;
    logic             ack_q, ack_d;
    logic             irq_q, irq_d;
    logic [31:0]      rdata_q, rdata_d;

    logic             wr_en;
    logic             rd_en;
    logic [NPINS-1:0] wdata_pins;
    logic [NPINS-1:0] rise;
    logic [NPINS-1:0] fall;
    logic [NPINS-1:0] hit;
    logic [NPINS-1:0] w1c;
    logic [31:0]      rd_mux;
    logic             unused_wdata;

    // Bits above NPINS may be ignored by the register file.
    assign unused_wdata = ^wdata_i;

    function automatic logic [31:0] zext(input logic [NPINS-1:0] v);
        logic [31:0] r;
        r = '0;
        r[NPINS-1:0] = v;
        return r;
    endfunction

    assign wr_en      = req_i & we_i;
    assign rd_en      = req_i & ~we_i;
    assign wdata_pins = wdata_i[NPINS-1:0];

    // Edge detection runs off the synchronized level regardless of direction.
    always_comb begin
        rise = sync2_q & ~prev_q;
        fall = ~sync2_q & prev_q;
        hit  = (pol_q & rise) | (~pol_q & fall);
    end

    always_comb begin
        rd_mux = '0;
        case (addr_i)
            AddrOut: rd_mux = zext(out_q);
            AddrDir: rd_mux = zext(dir_q);
            AddrIn:  rd_mux = zext(sync2_q);
            AddrIe:  rd_mux = zext(ie_q);
            AddrPol: rd_mux = zext(pol_q);
            AddrIs:  rd_mux = zext(is_q);
            default: rd_mux = '0;
        endcase
    end

    always_comb begin
        out_d   = out_q;
        dir_d   = dir_q;
        ie_d    = ie_q;
        pol_d   = pol_q;
        w1c     = '0;
        if (wr_en) begin
            case (addr_i)
                AddrOut: out_d = wdata_pins;
                AddrDir: dir_d = wdata_pins;
                AddrIe:  ie_d  = wdata_pins;
                AddrPol: pol_d = wdata_pins;
                AddrIs:  w1c   = wdata_pins;
                default: ;
            endcase
        end
        // A new edge overrides a simultaneous clear.
        is_d    = (is_q & ~w1c) | hit;
        sync1_d = gpio_i;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        ack_d   = req_i;
        rdata_d = rd_en ? rd_mux : 32'h0;
        irq_d   = |(is_q & ie_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q   <= '0;
            dir_q   <= '0;
            ie_q    <= '0;
            pol_q   <= '0;
            is_q    <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
            ack_q   <= 1'b0;
            irq_q   <= 1'b0;
            rdata_q <= 32'h0;
        end else begin
            out_q   <= out_d;
            dir_q   <= dir_d;
            ie_q    <= ie_d;
            pol_q   <= pol_d;
            is_q    <= is_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            ack_q   <= ack_d;
            irq_q   <= irq_d;
            rdata_q <= rdata_d;
        end
    end

    assign rdata_o   = rdata_q;
    assign ack_o     = ack_q;
    assign gpio_o    = out_q;
    assign gpio_oe_o = dir_q;
    assign irq_o     = irq_q;

endmodule

// File: tb/tb_gpio_ctrl.sv
// Directed plus randomized bench for gpio_ctrl, checked every cycle against a
// pin-history reference model of the register file and interrupt rules.
module tb_gpio_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_i = 1'b0;
    logic        we_i = 1'b0;
    logic [4:0]  addr_i = '0;
    logic [31:0] wdata_i = '0;
    logic [31:0] rdata_o;
    logic        ack_o;
    logic [23:0] gpio_i = '0;
    logic [23:0] gpio_o;
    logic [23:0] gpio_oe_o;
    logic        irq_o;

    int vectors = 0;
    int miscompares = 0;

    gpio_ctrl #(
        .NPINS (24),
        .ADDR_W(5)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_i    (req_i),
        .we_i     (we_i),
        .addr_i   (addr_i),
        .wdata_i  (wdata_i),
        .rdata_o  (rdata_o),
        .ack_o    (ack_o),
        .gpio_i   (gpio_i),
        .gpio_o   (gpio_o),
        .gpio_oe_o(gpio_oe_o),
        .irq_o    (irq_o)
    );

    always #5 clk = ~clk;

    // Reference model: register contents plus the pin levels seen 1, 2 and 3 edges ago.
    logic [23:0] m_out, m_dir, m_ie, m_pol, m_is;
    logic [23:0] seen1, seen2, seen3;
    logic        m_ack, m_irq;
    logic [31:0] m_rdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        logic [23:0] hit;
        logic [23:0] clr;
        logic [31:0] rd;
        if (rst) begin
            m_out = '0; m_dir = '0; m_ie = '0; m_pol = '0; m_is = '0;
            seen1 = '0; seen2 = '0; seen3 = '0;
            m_ack = 1'b0; m_irq = 1'b0; m_rdata = '0;
        end else begin
            // A pin hits when its visible level just changed to the polarity's target level.
            for (int i = 0; i < 24; i++)
                hit[i] = (seen2[i] != seen3[i]) && (seen2[i] == m_pol[i]);
            case (addr_i)
                5'h00:   rd = {8'h0, m_out};
                5'h04:   rd = {8'h0, m_dir};
                5'h08:   rd = {8'h0, seen2};
                5'h0C:   rd = {8'h0, m_ie};
                5'h10:   rd = {8'h0, m_pol};
                5'h14:   rd = {8'h0, m_is};
                default: rd = 32'h0;
            endcase
            m_ack   = req_i;
            m_rdata = (req_i && !we_i) ? rd : 32'h0;
            m_irq   = (m_is & m_ie) != 24'h0;
            clr = '0;
            if (req_i && we_i) begin
                case (addr_i)
                    5'h00:   m_out = wdata_i[23:0];
                    5'h04:   m_dir = wdata_i[23:0];
                    5'h0C:   m_ie  = wdata_i[23:0];
                    5'h10:   m_pol = wdata_i[23:0];
                    5'h14:   clr   = wdata_i[23:0];
                    default: ;
                endcase
            end
            m_is  = (m_is & ~clr) | hit;
            seen3 = seen2;
            seen2 = seen1;
            seen1 = gpio_i;
        end
    endtask

    // One bus cycle: drive, clock, advance model, compare all outputs.
    task automatic step(input logic r, input logic w, input logic [4:0] a, input logic [31:0] d);
        req_i   = r;
        we_i    = w;
        addr_i  = a;
        wdata_i = d;
        @(posedge clk);
        model_edge();
        #1;
        chk("ack_o", {31'h0, ack_o}, {31'h0, m_ack});
        chk("rdata_o", rdata_o, m_rdata);
        chk("gpio_o", {8'h0, gpio_o}, {8'h0, m_out});
        chk("gpio_oe_o", {8'h0, gpio_oe_o}, {8'h0, m_dir});
        chk("irq_o", {31'h0, irq_o}, {31'h0, m_irq});
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 5'h00, 32'h0);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        step(1'b1, 1'b1, a, d);
    endtask

    task automatic rd(input logic [4:0] a);
        step(1'b1, 1'b0, a, 32'h0);
    endtask

    initial begin
        // Reset held two cycles with a pending request.
        rst = 1'b1;
        step(1'b1, 1'b0, 5'h00, 32'h0);
        step(1'b1, 1'b1, 5'h04, 32'hFFFFFFFF);
        chk("rst_ack", {31'h0, ack_o}, 32'h0);
        chk("rst_oe", {8'h0, gpio_oe_o}, 32'h0);
        chk("rst_irq", {31'h0, irq_o}, 32'h0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            rd(5'(i * 4));
            chk("rst_reg", rdata_o, 32'h0);
            chk("rst_rd_ack", {31'h0, ack_o}, 32'h1);
        end

        // Output path.
        wr(5'h04, 32'hFF0000FF);
        wr(5'h00, 32'hFFA5A5A5);
        chk("oe_val", {8'h0, gpio_oe_o}, 32'h000000FF);
        chk("out_val", {8'h0, gpio_o}, 32'h00A5A5A5);
        rd(5'h00);
        chk("out_read", rdata_o, 32'h00A5A5A5);
        idle();
        chk("ack_one_cycle", {31'h0, ack_o}, 32'h0);
        chk("rdata_idle", rdata_o, 32'h0);

        // Input synchronizer latency.
        gpio_i = 24'h123456;
        idle();
        rd(5'h08);
        chk("in_t1_old", rdata_o, 32'h0);
        rd(5'h08);
        chk("in_t2_new", rdata_o, 32'h00123456);

        // Rising-edge interrupt on pin 0.
        gpio_i = '0;
        repeat (4) idle();
        wr(5'h14, 32'h00FFFFFF);
        wr(5'h0C, 32'h1);
        wr(5'h10, 32'h1);
        gpio_i = 24'h000001;
        idle();
        idle();
        idle();
        chk("irq_t3_low", {31'h0, irq_o}, 32'h0);
        rd(5'h14);
        chk("is0_set", rdata_o, 32'h1);
        chk("irq_t4_high", {31'h0, irq_o}, 32'h1);
        wr(5'h14, 32'h1);
        chk("irq_hold", {31'h0, irq_o}, 32'h1);
        idle();
        chk("irq_cleared", {31'h0, irq_o}, 32'h0);

        // Masked falling edge on pin 5, then unmask.
        gpio_i = 24'h000021;
        repeat (4) idle();
        gpio_i = 24'h000001;
        repeat (4) idle();
        rd(5'h14);
        chk("is5_masked", rdata_o, 32'h20);
        chk("irq_masked", {31'h0, irq_o}, 32'h0);
        wr(5'h0C, 32'h21);
        chk("irq_pre_unmask", {31'h0, irq_o}, 32'h0);
        idle();
        chk("irq_unmask", {31'h0, irq_o}, 32'h1);

        // Set/clear collision on pin 3.
        wr(5'h14, 32'h00FFFFFF);
        wr(5'h10, 32'h9);
        gpio_i = 24'h000009;
        idle();
        idle();
        wr(5'h14, 32'h8);
        rd(5'h14);
        chk("collide_set_wins", rdata_o, 32'h8);
        wr(5'h14, 32'h8);
        rd(5'h14);
        chk("w1c_after", rdata_o, 32'h0);

        // Unmapped offsets ack and read zero.
        wr(5'h18, 32'hFFFFFFFF);
        rd(5'h1C);
        chk("unmapped", rdata_o, 32'h0);

        // Randomized traffic with pin activity and occasional mid-access reset.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) gpio_i = 24'($urandom);
            rst = ($urandom_range(0, 59) == 0);
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 7) * 4), $urandom);
        end
        rst = 1'b0;
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
